// File: rtl/mac_filter.sv
`default_nettype none
// ============================================================================
//  Module   : mac_filter
//  Purpose  : Receive-path Ethernet header filter. Parses the 14-byte header
//             (56 dibits, MSB-first per byte) of each frame and forwards only
//             the payload+FCS dibits of frames addressed to this station or to
//             broadcast, with a matching EtherType. Rejected frames increment
//             a saturating drop counter.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             axiiv, axiid    - input dibit valid / data (valid spans frame)
//             axiov, axiod    - output dibit valid / data (latency 1)
//             drop_count      - frames rejected since reset, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module mac_filter #(
   parameter logic [47:0] MY_MAC          = 48'h69_69_5A_06_54_91,
   parameter logic [15:0] ETHERTYPE       = 16'h0800,
   parameter bit          CHECK_ETHERTYPE = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        axiiv,
   input  logic [1:0]  axiid,
   output logic        axiov,
   output logic [1:0]  axiod,
   output logic [15:0] drop_count
);

   localparam logic [5:0] C_DST_END   = 6'd24;  // first source-MAC dibit
   localparam logic [5:0] C_ET_START  = 6'd48;  // first EtherType dibit
   localparam logic [5:0] C_HDR_LAST  = 6'd55;  // last header dibit
   localparam logic [5:0] C_IDX_MAX   = 6'd56;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_HDR      = 3'd1,
      S_PASS     = 3'd2,
      S_DROP     = 3'd3,
      S_WAIT_END = 3'd4
   } state_t;

   state_t      state_q;
   logic [5:0]  idx_q, idx_d;
   logic        uc_ok_q, bc_ok_q, et_ok_q;
   logic        post_rst_q;
   logic        axiov_q;
   logic [1:0]  axiod_q;
   logic [15:0] drop_count_q, drop_count_d;

   logic [1:0]  w_mac_dibit;
   logic [1:0]  w_et_dibit;
   logic        w_uc_hit, w_bc_hit, w_et_hit;
   logic        w_accept;

   // Expected dibit for the current index. Only meaningful while the index
   // is inside the relevant header field; out-of-field values are ignored.
   assign w_mac_dibit = 2'(MY_MAC >> (6'd46 - {idx_q[4:0], 1'b0}));
   assign w_et_dibit  = 2'(ETHERTYPE >> (4'd14 - {idx_q[2:0], 1'b0}));

   assign w_uc_hit = (axiid == w_mac_dibit);
   assign w_bc_hit = (axiid == 2'b11);
   assign w_et_hit = (axiid == w_et_dibit);

   // Evaluated at the last header dibit: destination flags are final, the
   // EtherType flag still needs the dibit being presented this cycle.
   assign w_accept = (uc_ok_q | bc_ok_q) &
                     ((et_ok_q & w_et_hit) | ~CHECK_ETHERTYPE);

   assign idx_d        = (idx_q == C_IDX_MAX) ? idx_q : idx_q + 6'd1;
   assign drop_count_d = (drop_count_q == 16'hFFFF) ? drop_count_q
                                                    : drop_count_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         idx_q        <= 6'd0;
         uc_ok_q      <= 1'b0;
         bc_ok_q      <= 1'b0;
         et_ok_q      <= 1'b0;
         post_rst_q   <= 1'b1;
         axiov_q      <= 1'b0;
         axiod_q      <= 2'b00;
         drop_count_q <= 16'd0;
      end else begin
         post_rst_q <= 1'b0;
         axiov_q    <= 1'b0;
         axiod_q    <= 2'b00;
         case (state_q)
            S_IDLE: begin
               idx_q <= 6'd0;
               if (axiiv) begin
                  // A frame already in flight when reset released is not
                  // trusted: skip it entirely.
                  if (post_rst_q) begin
                     state_q <= S_WAIT_END;
                  end else begin
                     state_q <= S_HDR;
                     idx_q   <= 6'd1;
                     uc_ok_q <= w_uc_hit;
                     bc_ok_q <= w_bc_hit;
                     et_ok_q <= 1'b1;
                  end
               end
            end
            S_HDR: begin
               if (!axiiv) begin
                  // Runt: frame ended inside the header.
                  state_q      <= S_IDLE;
                  idx_q        <= 6'd0;
                  drop_count_q <= drop_count_d;
               end else begin
                  idx_q <= idx_d;
                  if (idx_q < C_DST_END) begin
                     uc_ok_q <= uc_ok_q & w_uc_hit;
                     bc_ok_q <= bc_ok_q & w_bc_hit;
                  end
                  if (idx_q >= C_ET_START) begin
                     et_ok_q <= et_ok_q & w_et_hit;
                  end
                  if (idx_q == C_HDR_LAST) begin
                     if (w_accept) begin
                        state_q <= S_PASS;
                     end else begin
                        state_q      <= S_DROP;
                        drop_count_q <= drop_count_d;
                     end
                  end
               end
            end
            S_PASS: begin
               if (axiiv) begin
                  axiov_q <= 1'b1;
                  axiod_q <= axiid;
               end else begin
                  state_q <= S_IDLE;
                  idx_q   <= 6'd0;
               end
            end
            S_DROP, S_WAIT_END: begin
               if (!axiiv) begin
                  state_q <= S_IDLE;
                  idx_q   <= 6'd0;
               end
            end
            default: begin
               state_q <= S_IDLE;
               idx_q   <= 6'd0;
            end
         endcase
      end
   end

   assign axiov      = axiov_q;
   assign axiod      = axiod_q;
   assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_filter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_filter
//  Purpose  : Self-checking bench for mac_filter. Two instances share the
//             input stream, one enforcing EtherType and one ignoring it.
//             Expected output is derived per frame from the header rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_filter;

   localparam logic [47:0] C_MAC = 48'h69_69_5A_06_54_91;
   localparam logic [15:0] C_ET  = 16'h0800;

   logic        clk = 1'b0;
   logic        rst;
   logic        axiiv;
   logic [1:0]  axiid;
   logic        ov1, ov0;
   logic [1:0]  od1, od0;
   logic [15:0] dc1, dc0;

   always #10 clk = ~clk;

   mac_filter #(.MY_MAC(C_MAC), .ETHERTYPE(C_ET), .CHECK_ETHERTYPE(1'b1)) dut1 (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
      .axiov(ov1), .axiod(od1), .drop_count(dc1));

   mac_filter #(.MY_MAC(C_MAC), .ETHERTYPE(C_ET), .CHECK_ETHERTYPE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
      .axiov(ov0), .axiod(od0), .drop_count(dc0));

   int          total = 0;
   int          bad   = 0;
   int          step  = 0;
   logic [1:0]  rx1[$], rx0[$];
   int          st1[$], st0[$];
   logic [15:0] mdrop1 = 16'd0, mdrop0 = 16'd0;

   // ---------------- reference model ----------------
   function automatic bit model_acc(input logic [1:0] d[$], input bit chk);
      logic [47:0] dst = '0;
      logic [15:0] t   = '0;
      if (d.size() < 56) return 1'b0;
      for (int i = 0; i < 24; i++) dst = {dst[45:0], d[i]};
      for (int i = 48; i < 56; i++) t = {t[13:0], d[i]};
      return ((dst == C_MAC) || (dst == 48'hFFFF_FFFF_FFFF)) && (!chk || t == C_ET);
   endfunction

   function automatic void expect_q(input logic [1:0] d[$], input bit chk,
                                    output logic [1:0] e[$]);
      e = {};
      if (model_acc(d, chk))
         for (int i = 56; i < d.size(); i++) e.push_back(d[i]);
   endfunction

   function automatic int qdiff(input logic [1:0] a[$], input logic [1:0] b[$]);
      int n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
      for (int i = 0; i < a.size() && i < b.size(); i++)
         if (a[i] !== b[i]) n++;
      return n;
   endfunction

   function automatic void build(input logic [47:0] dst, input logic [15:0] typ,
                                 input logic [7:0] pay[$], output logic [1:0] d[$]);
      logic [7:0] b[$];
      d = {};
      for (int i = 5; i >= 0; i--) b.push_back(dst[i*8 +: 8]);
      for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
      b.push_back(typ[15:8]);
      b.push_back(typ[7:0]);
      foreach (pay[i]) b.push_back(pay[i]);
      foreach (b[i])
         for (int j = 3; j >= 0; j--) d.push_back(b[i][2*j +: 2]);
   endfunction

   // ---------------- stimulus plumbing ----------------
   task automatic tick();
      @(negedge clk);
      if (ov1) begin rx1.push_back(od1); st1.push_back(step); end
      if (ov0) begin rx0.push_back(od0); st0.push_back(step); end
      step++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         axiiv = 1'b0;
         axiid = 2'b00;
      end
   endtask

   task automatic clear();
      rx1.delete(); rx0.delete(); st1.delete(); st0.delete();
   endtask

   task automatic send(input logic [1:0] d[$], output int s0);
      s0 = 0;
      for (int k = 0; k < d.size(); k++) begin
         tick();
         if (k == 0) s0 = step - 1;
         axiiv = 1'b1;
         axiid = d[k];
      end
      tick();
      axiiv = 1'b0;
      axiid = 2'b00;
      if (!model_acc(d, 1'b1) && mdrop1 != 16'hFFFF) mdrop1++;
      if (!model_acc(d, 1'b0) && mdrop0 != 16'hFFFF) mdrop0++;
   endtask

   function automatic void std_payload(output logic [7:0] p[$]);
      p = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hF0, 8'h0D,
            8'h12, 8'h34, 8'h56, 8'h78};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; axiiv = 1'b0; axiid = 2'b00;
      idle(3);
      tick();
      total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL reset_axiov: got %b want 0", ov1); end
      total++; if (od1 !== 2'b00) begin bad++; $display("FAIL reset_axiod: got %b want 00", od1); end
      total++; if (dc1 !== 16'd0 || dc0 !== 16'd0) begin bad++; $display("FAIL reset_drop: got %h/%h want 0", dc1, dc0); end
      rst = 1'b0;
      idle(2);
      clear();
   endtask

   task automatic test_unicast(input logic [47:0] dst, input string nm);
      logic [7:0] p[$]; logic [1:0] d[$], e[$]; int s0;
      std_payload(p);
      build(dst, C_ET, p, d);
      expect_q(d, 1'b1, e);
      clear(); send(d, s0); idle(3);
      total++; if (rx1.size() != 48 || qdiff(rx1, e) != 0) begin bad++;
         $display("FAIL %s_payload: got %0d dibits (%0d diffs) want 48", nm, rx1.size(), qdiff(rx1, e)); end
      total++; if (st1.size() == 0 || st1[0] != s0 + 57 || st1[st1.size()-1] != s0 + 104) begin bad++;
         $display("FAIL %s_timing: got first=%0d last=%0d want %0d..%0d", nm,
                  st1.size() ? st1[0] - s0 : -1, st1.size() ? st1[st1.size()-1] - s0 : -1, 57, 104); end
      total++; if (rx1.size() < 4 || rx1[0] !== 2'b11 || rx1[1] !== 2'b01 || rx1[2] !== 2'b11 || rx1[3] !== 2'b10) begin bad++;
         $display("FAIL %s_first4: got %0d dibits, head differs from 11,01,11,10", nm, rx1.size()); end
      total++; if (dc1 !== mdrop1) begin bad++; $display("FAIL %s_drop: got %0d want %0d", nm, dc1, mdrop1); end
   endtask

   task automatic test_dst_mismatch();
      logic [7:0] p[$]; logic [1:0] d[$]; int s0;
      std_payload(p);
      build(48'h69_69_5A_06_54_92, C_ET, p, d);
      clear(); send(d, s0); idle(3);
      total++; if (rx1.size() != 0 || rx0.size() != 0) begin bad++;
         $display("FAIL dst_mismatch_out: got %0d/%0d dibits want 0", rx1.size(), rx0.size()); end
      total++; if (dc1 !== mdrop1 || dc1 !== 16'd1) begin bad++;
         $display("FAIL dst_mismatch_drop: got %0d want %0d", dc1, mdrop1); end
   endtask

   task automatic test_ethertype();
      logic [7:0] p[$]; logic [1:0] d[$], e0[$]; int s0;
      std_payload(p);
      build(C_MAC, 16'h86DD, p, d);
      expect_q(d, 1'b0, e0);
      clear(); send(d, s0); idle(3);
      total++; if (rx1.size() != 0) begin bad++; $display("FAIL et_check_out: got %0d dibits want 0", rx1.size()); end
      total++; if (dc1 !== mdrop1) begin bad++; $display("FAIL et_check_drop: got %0d want %0d", dc1, mdrop1); end
      total++; if (rx0.size() != 48 || qdiff(rx0, e0) != 0) begin bad++;
         $display("FAIL et_ignore_out: got %0d dibits (%0d diffs) want 48", rx0.size(), qdiff(rx0, e0)); end
      total++; if (dc0 !== mdrop0) begin bad++; $display("FAIL et_ignore_drop: got %0d want %0d", dc0, mdrop0); end
   endtask

   task automatic test_runt();
      logic [7:0] p[$]; logic [1:0] d[$], r[$], e[$]; int s0, sr;
      std_payload(p);
      build(C_MAC, C_ET, p, d);
      for (int i = 0; i < 30; i++) r.push_back(d[i]);
      expect_q(d, 1'b1, e);
      clear();
      send(r, sr);
      send(d, s0);
      idle(3);
      total++; if (qdiff(rx1, e) != 0) begin bad++;
         $display("FAIL runt_next_frame: got %0d dibits (%0d diffs) want %0d", rx1.size(), qdiff(rx1, e), e.size()); end
      total++; if (st1.size() == 0 || st1[0] != s0 + 57) begin bad++;
         $display("FAIL runt_next_latency: got %0d want 57", st1.size() ? st1[0] - s0 : -1); end
      total++; if (dc1 !== mdrop1) begin bad++; $display("FAIL runt_drop: got %0d want %0d", dc1, mdrop1); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] p[$]; logic [1:0] a[$], b[$], e[$], eb[$]; int sa, sb;
      for (int i = 0; i < 5; i++) p.push_back(8'($urandom));
      build(48'hFFFF_FFFF_FFFF, C_ET, p, a);
      p.delete();
      for (int i = 0; i < 7; i++) p.push_back(8'($urandom));
      build(C_MAC, C_ET, p, b);
      expect_q(a, 1'b1, e);
      expect_q(b, 1'b1, eb);
      foreach (eb[i]) e.push_back(eb[i]);
      clear(); send(a, sa); send(b, sb); idle(3);
      total++; if (qdiff(rx1, e) != 0) begin bad++;
         $display("FAIL b2b_payload: got %0d dibits (%0d diffs) want %0d", rx1.size(), qdiff(rx1, e), e.size()); end
      total++; if (st1.size() != 48 || st1[20] != sb + 57) begin bad++;
         $display("FAIL b2b_second_latency: got %0d dibits, second start %0d want 57", st1.size(),
                  st1.size() > 20 ? st1[20] - sb : -1); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] p[$]; logic [1:0] d[$], e[$]; int s0;
      for (int i = 0; i < 30; i++) p.push_back(8'($urandom));
      build(C_MAC, C_ET, p, d);
      for (int i = 56; i < 76; i++) e.push_back(d[i]);
      clear();
      for (int k = 0; k < d.size(); k++) begin
         tick();
         if (k == 0) s0 = step - 1;
         axiiv = 1'b1;
         axiid = d[k];
         rst   = (k == 76);
      end
      tick();
      axiiv = 1'b0; rst = 1'b0;
      mdrop1 = 16'd0; mdrop0 = 16'd0;
      idle(3);
      total++; if (qdiff(rx1, e) != 0) begin bad++;
         $display("FAIL rst_mid_out: got %0d dibits (%0d diffs) want 20", rx1.size(), qdiff(rx1, e)); end
      total++; if (st1.size() == 0 || st1[st1.size()-1] != s0 + 76) begin bad++;
         $display("FAIL rst_mid_last: got %0d want 76", st1.size() ? st1[st1.size()-1] - s0 : -1); end
      total++; if (dc1 !== 16'd0) begin bad++; $display("FAIL rst_mid_drop: got %0d want 0", dc1); end
      p.delete();
      for (int i = 0; i < 6; i++) p.push_back(8'($urandom));
      build(C_MAC, C_ET, p, d);
      expect_q(d, 1'b1, e);
      clear(); send(d, s0); idle(3);
      total++; if (qdiff(rx1, e) != 0 || e.size() != 24) begin bad++;
         $display("FAIL rst_mid_next: got %0d dibits (%0d diffs) want 24", rx1.size(), qdiff(rx1, e)); end
   endtask

   task automatic test_random();
      logic [7:0] p[$]; logic [1:0] d[$], t[$], e1[$], e0[$]; logic [47:0] dst; logic [15:0] typ; int s0;
      for (int f = 0; f < 24; f++) begin
         case ($urandom_range(0, 3))
            0: dst = C_MAC;
            1: dst = 48'hFFFF_FFFF_FFFF;
            2: dst = C_MAC ^ (48'd1 << $urandom_range(0, 47));
            default: dst = {16'($urandom), 32'($urandom)};
         endcase
         typ = $urandom_range(0, 1) ? C_ET : 16'($urandom);
         p.delete();
         for (int i = 0; i < int'($urandom_range(0, 16)); i++) p.push_back(8'($urandom));
         build(dst, typ, p, d);
         if ($urandom_range(0, 4) == 0) begin
            t = {};
            for (int i = 0; i < int'($urandom_range(1, 55)); i++) t.push_back(d[i]);
            d = t;
         end
         expect_q(d, 1'b1, e1);
         expect_q(d, 1'b0, e0);
         clear(); send(d, s0); idle($urandom_range(2, 4));
         total++; if (qdiff(rx1, e1) != 0 || (st1.size() > 0 && st1[0] != s0 + 57)) begin bad++;
            $display("FAIL rand%0d_chk_out: got %0d dibits (%0d diffs) want %0d", f, rx1.size(), qdiff(rx1, e1), e1.size()); end
         total++; if (qdiff(rx0, e0) != 0) begin bad++;
            $display("FAIL rand%0d_nochk_out: got %0d dibits (%0d diffs) want %0d", f, rx0.size(), qdiff(rx0, e0), e0.size()); end
         total++; if (dc1 !== mdrop1 || dc0 !== mdrop0) begin bad++;
            $display("FAIL rand%0d_drop: got %0d/%0d want %0d/%0d", f, dc1, dc0, mdrop1, mdrop0); end
      end
   endtask

   task automatic test_saturation();
      logic [1:0] d[$]; int s0;
      tick();
      force dut1.drop_count_q = 16'hFFFD;
      force dut0.drop_count_q = 16'hFFFD;
      tick(); tick();
      release dut1.drop_count_q;
      release dut0.drop_count_q;
      mdrop1 = 16'hFFFD; mdrop0 = 16'hFFFD;
      d = {2'b11};
      for (int i = 0; i < 4; i++) begin
         send(d, s0); idle(1);
         total++; if (dc1 !== mdrop1 || dc0 !== mdrop0) begin bad++;
            $display("FAIL sat_step%0d: got %h/%h want %h", i, dc1, dc0, mdrop1); end
      end
      total++; if (dc1 !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want FFFF", dc1); end
   endtask

   initial begin
      rst = 1'b1; axiiv = 1'b0; axiid = 2'b00;
      test_reset();
      test_unicast(C_MAC, "unicast");
      test_unicast(48'hFFFF_FFFF_FFFF, "broadcast");
      test_reset();
      test_dst_mismatch();
      test_ethertype();
      test_runt();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
